logic_ex: RTL and testbench

// - Board-level logic-gate demo: two slide switches drive four LEDs showing
//   NOT, AND, OR and XOR of the switch inputs.
// - Sits directly under the board top.
// - Switches are asynchronous board inputs: they are synchronized, optionally

---
 rtl/logic_ex_pkg.sv | 24 ++
 rtl/logic_ex_if.sv | 19 +
 rtl/logic_ex_sw_conditioner.sv | 75 +++++++
 rtl/logic_ex.sv | 56 +++++
 tb/tb_logic_ex.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/logic_ex_pkg.sv
// -----------------------------------------------------------------------------
// logic_ex_pkg
// Shared widths, LED bit positions and reset value for the logic-gate demo.
// Optional feature macro used by this design: LOGIC_EX_DEBOUNCE_EN
// (switch debounce inside sw_conditioner).
// -----------------------------------------------------------------------------
package logic_ex_pkg;

    localparam int SW_W  = 2;
    localparam int LED_W = 4;

    // LED bit positions
    localparam int LED_NOT = 0;
    localparam int LED_AND = 1;
    localparam int LED_OR  = 2;
    localparam int LED_XOR = 3;

    // Decode of SW=00: only the NOT gate is lit
    localparam logic [LED_W-1:0] LED_RST = 4'b0001;

    typedef logic [SW_W-1:0]  sw_t;
    typedef logic [LED_W-1:0] led_t;

endpackage

// File: rtl/logic_ex_if.sv
// -----------------------------------------------------------------------------
// logic_ex_if
// Board-side bundle for the logic-gate demo.
//   SW  : slide switches (asynchronous to clk), driven by the board
//   LED : gate outputs, driven by logic_ex
// Modports:
//   master : board / stimulus side (drives SW, observes LED)
//   slave  : logic_ex side (observes SW, drives LED)
// -----------------------------------------------------------------------------
interface logic_ex_if;
    import logic_ex_pkg::*;

    sw_t  SW;
    led_t LED;

    modport master (output SW, input LED);
    modport slave  (input SW, output LED);

endinterface

// File: rtl/logic_ex_sw_conditioner.sv
// -----------------------------------------------------------------------------
// sw_conditioner
// Per-bit multi-flop synchronizer for asynchronous switch inputs, followed by
// an optional per-bit debounce filter (macro LOGIC_EX_DEBOUNCE_EN).
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears all flops to 0
//   din  in   W raw switch bits (asynchronous)
//   dout out  W conditioned switch bits
// Parameters:
//   W               bit count
//   SYNC_STAGES     synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES stable cycles needed to accept a change (debounce build)
// -----------------------------------------------------------------------------
module sw_conditioner #(
    parameter int W               = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("sw_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [W-1:0] sync_p [SYNC_STAGES];

    // Synchronizer stages: all bits captured on the same edge, no realignment
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
        end else begin
            sync_p[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
        end
    end

`ifdef LOGIC_EX_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     acc_p;
    logic [CNT_W-1:0] cnt_p [W];

    // Debounce stage: the counter runs only while the synchronized bit differs
    // from the accepted bit; any cycle where they agree restarts it, so a
    // change is accepted on its DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p <= '0;
            for (int b = 0; b < W; b++) cnt_p[b] <= '0;
        end else begin
            for (int b = 0; b < W; b++) begin
                if (sync_p[SYNC_STAGES-1][b] == acc_p[b]) begin
                    cnt_p[b] <= '0;
                end else if (cnt_p[b] == CNT_LAST) begin
                    acc_p[b] <= sync_p[SYNC_STAGES-1][b];
                    cnt_p[b] <= '0;
                end else begin
                    cnt_p[b] <= cnt_p[b] + CNT_W'(1);
                end
            end
        end
    end

    assign dout = acc_p;
`else
    assign dout = sync_p[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/logic_ex.sv
// -----------------------------------------------------------------------------
// logic_ex
// Logic-gate demo: two slide switches drive four LEDs showing NOT, AND, OR and
// XOR of the conditioned switch value. Sits directly under the board top.
// Optional macro: LOGIC_EX_DEBOUNCE_EN adds per-bit switch debounce.
// Ports:
//   clk      in   system clock, rising-edge
//   rst      in   synchronous active-high reset (LED -> 4'b0001)
//   io.SW    in   2 slide switches, asynchronous to clk
//   io.LED   out  [0]=~s[0] [1]=s[1]&s[0] [2]=s[1]|s[0] [3]=s[1]^s[0]
// Latency SW->LED: SYNC_STAGES+1 cycles (plus DEBOUNCE_CYCLES with debounce).
// -----------------------------------------------------------------------------
module logic_ex
    import logic_ex_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    logic_ex_if.slave  io
);

    sw_t  s;
    led_t led_p;

    function automatic led_t gate_decode(input sw_t v);
        led_t r;
        r          = '0;
        r[LED_NOT] = ~v[0];
        r[LED_AND] = &v;
        r[LED_OR]  = |v;
        r[LED_XOR] = ^v;
        return r;
    endfunction

    sw_conditioner #(
        .W               (SW_W),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
        .clk  (clk),
        .rst  (rst),
        .din  (io.SW),
        .dout (s)
    );

    // LED stage: all four gates registered together from one value of s
    always_ff @(posedge clk) begin
        if (rst) led_p <= LED_RST;
        else     led_p <= gate_decode(s);
    end

    assign io.LED = led_p;

endmodule

// File: tb/tb_logic_ex.sv
// -----------------------------------------------------------------------------
// tb_logic_ex
// Directed stimulus for logic_ex with a cycle-tagged scoreboard of expected LED
// values. A behavioural switch model (per-bit stability runs) decides which
// switch value the board should be showing, and the expected LED pattern is
// queued with the cycle on which it must appear.
// -----------------------------------------------------------------------------
module tb_logic_ex;

    localparam int SYNC = 2;
`ifdef LOGIC_EX_DEBOUNCE_EN
    localparam int M     = 1;
    localparam int DEB_M = 4;
`else
    localparam int M     = 0;
    localparam int DEB_M = 1;
`endif

    typedef struct {
        int         due;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic_ex_if bus ();

    logic_ex #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    exp_t sbq[$];
    int   cyc      = 0;
    int   total    = 0;
    int   pass_cnt = 0;

    logic [1:0] run_val;
    int         run_len [2];
    logic [1:0] stable;

    // Required LED for each switch position (bit3..0 = XOR OR AND NOT)
    function automatic logic [3:0] ref_led(input logic [1:0] sw);
        case (sw)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b1100;
            2'b10:   return 4'b1101;
            default: return 4'b0110;
        endcase
    endfunction

    task automatic tick(input string tag, input logic [1:0] sw, input logic r);
        exp_t e;
        @(negedge clk);
        bus.SW = sw;
        rst    = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            sbq.delete();
            run_val = 2'b00;
            stable  = 2'b00;
            for (int b = 0; b < 2; b++) run_len[b] = DEB_M;
            for (int k = 0; k < SYNC + 1 + M; k++) begin
                e.due = cyc + k;
                e.val = 4'b0001;
                sbq.push_back(e);
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sw[b] == run_val[b]) begin
                    if (run_len[b] < 1000) run_len[b]++;
                end else begin
                    run_val[b] = sw[b];
                    run_len[b] = 1;
                end
                if (run_len[b] >= DEB_M) stable[b] = run_val[b];
            end
            e.due = cyc + SYNC + M;
            e.val = ref_led(stable);
            sbq.push_back(e);
        end
        #1;
        total++;
        if (sbq.size() == 0) begin
            $error("FAIL %s sb_empty: cycle=%0d no expectation queued", tag, cyc);
        end else begin
            e = sbq.pop_front();
            assert (bus.LED === e.val && e.due == cyc) pass_cnt++;
            else $error("FAIL %s cycle=%0d: LED=%b expected %b (due %0d)",
                        tag, cyc, bus.LED, e.val, e.due);
        end
    endtask

    task automatic hold(input string tag, input logic [1:0] sw, input logic r, input int n);
        for (int i = 0; i < n; i++) tick(tag, sw, r);
    endtask

    initial begin
        bus.SW = 2'b00;
        run_val = 2'b00;
        stable  = 2'b00;
        for (int b = 0; b < 2; b++) run_len[b] = DEB_M;

        // Reset held with SW=01, then release and watch 1100 arrive
        hold("reset",      2'b01, 1'b1, 3);
        hold("post_reset", 2'b01, 1'b0, 10);

        // Exhaustive sweep, 100 ns (10 cycles) per position
        hold("sweep_00", 2'b00, 1'b0, 10);
        hold("sweep_01", 2'b01, 1'b0, 10);
        hold("sweep_10", 2'b10, 1'b0, 10);
        hold("sweep_11", 2'b11, 1'b0, 10);

        // Latency: both bits change on one edge, no intermediate pattern
        hold("lat_00", 2'b00, 1'b0, 10);
        hold("lat_11", 2'b11, 1'b0, 10);

        // Mid-run one-cycle reset with SW=11
        hold("midrst",     2'b11, 1'b1, 1);
        hold("midrst_rel", 2'b11, 1'b0, 10);

        // Switch change while reset is asserted
        hold("rst_chg",     2'b10, 1'b1, 2);
        hold("rst_chg_rel", 2'b10, 1'b0, 10);

        // Two-cycle glitch 00 -> 01 -> 00
        hold("glitch_pre",  2'b00, 1'b0, 10);
        hold("glitch",      2'b01, 1'b0, 2);
        hold("glitch_post", 2'b00, 1'b0, 10);

        // Held change 00 -> 01 for 10 cycles
        hold("held_01",   2'b01, 1'b0, 10);
        hold("held_back", 2'b00, 1'b0, 10);

        // Single-bit glitch on the upper bit while the lower bit is steady
        hold("glitch_b1",      2'b11, 1'b0, 3);
        hold("glitch_b1_post", 2'b01, 1'b0, 12);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
